// File: rtl/bg_fill_pkg.sv
// Shared constants for the background fill engine: register addresses,
// MODE bit positions and default parameter values.
// Optional feature macro: BG_SCROLL_EN (scroll registers and adders).
package bg_fill_pkg;

  // Default parameter values
  localparam int BG_INDEX_W       = 9;
  localparam int BG_COORD_W       = 10;
  localparam int BG_TILE_LOG2     = 3;
  localparam int BG_MAP_COLS_LOG2 = 6;
  localparam int BG_MAP_ROWS_LOG2 = 5;
  localparam int BG_TRANSPARENT   = 0;

  // Register addresses
  localparam logic [1:0] BG_REG_MODE    = 2'd0;
  localparam logic [1:0] BG_REG_SOLID   = 2'd1;
  localparam logic [1:0] BG_REG_SCROLLX = 2'd2;
  localparam logic [1:0] BG_REG_SCROLLY = 2'd3;

  // MODE register bit positions
  localparam int BG_MODE_FILL_BIT = 0;
  localparam int BG_MODE_TILE_BIT = 1;

  // True when a register write strobe targets the given address
  function automatic logic bg_reg_hit(input logic we, input logic [1:0] addr,
                                      input logic [1:0] sel);
    return we && (addr == sel);
  endfunction

endpackage

// File: rtl/bg_fill_regs.sv
// Double-buffered register file for the background fill engine.
// Writes land in the pending copy; frameStart copies pending to active.
// A write in the same cycle as frameStart reaches both copies. The outputs
// are the effective values for the current sampling edge: when frameStart
// is high they already reflect the commit, so a pixel sampled on the commit
// edge sees the new settings.
// Optional feature macro: BG_SCROLL_EN adds the SCROLLX/SCROLLY registers.
module bg_fill_regs
  import bg_fill_pkg::*;
#(
  parameter int INDEX_W = BG_INDEX_W
`ifdef BG_SCROLL_EN
  ,
  parameter int COORD_W = BG_COORD_W
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frameStart,
  input  logic               regWe,
  input  logic [1:0]         regAddr,
  input  logic [15:0]        regData,
`ifdef BG_SCROLL_EN
  output logic [COORD_W-1:0] scroll_x,
  output logic [COORD_W-1:0] scroll_y,
`endif
  output logic               fill_en,
  output logic               tile_en,
  output logic [INDEX_W-1:0] solid
);

  logic               pend_fill, pend_tile;
  logic [INDEX_W-1:0] pend_solid;
  logic               act_fill, act_tile;
  logic [INDEX_W-1:0] act_solid;
  logic               nxt_fill, nxt_tile;
  logic [INDEX_W-1:0] nxt_solid;
  logic               unused_data;

`ifdef BG_SCROLL_EN
  logic [COORD_W-1:0] pend_sx, pend_sy, act_sx, act_sy, nxt_sx, nxt_sy;
`endif

  // High data bits beyond each field are intentionally dropped
  assign unused_data = ^regData;

  // Pending copy with this cycle's write applied
  always_comb begin
    nxt_fill  = pend_fill;
    nxt_tile  = pend_tile;
    nxt_solid = pend_solid;
`ifdef BG_SCROLL_EN
    nxt_sx    = pend_sx;
    nxt_sy    = pend_sy;
`endif
    if (bg_reg_hit(regWe, regAddr, BG_REG_MODE)) begin
      nxt_fill = regData[BG_MODE_FILL_BIT];
      nxt_tile = regData[BG_MODE_TILE_BIT];
    end
    if (bg_reg_hit(regWe, regAddr, BG_REG_SOLID)) begin
      nxt_solid = regData[INDEX_W-1:0];
    end
`ifdef BG_SCROLL_EN
    if (bg_reg_hit(regWe, regAddr, BG_REG_SCROLLX)) begin
      nxt_sx = regData[COORD_W-1:0];
    end
    if (bg_reg_hit(regWe, regAddr, BG_REG_SCROLLY)) begin
      nxt_sy = regData[COORD_W-1:0];
    end
`endif
  end

  // Pending and active register storage
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_fill  <= 1'b0;
      pend_tile  <= 1'b0;
      pend_solid <= '0;
      act_fill   <= 1'b0;
      act_tile   <= 1'b0;
      act_solid  <= '0;
`ifdef BG_SCROLL_EN
      pend_sx    <= '0;
      pend_sy    <= '0;
      act_sx     <= '0;
      act_sy     <= '0;
`endif
    end else begin
      pend_fill  <= nxt_fill;
      pend_tile  <= nxt_tile;
      pend_solid <= nxt_solid;
`ifdef BG_SCROLL_EN
      pend_sx    <= nxt_sx;
      pend_sy    <= nxt_sy;
`endif
      if (frameStart) begin
        act_fill  <= nxt_fill;
        act_tile  <= nxt_tile;
        act_solid <= nxt_solid;
`ifdef BG_SCROLL_EN
        act_sx    <= nxt_sx;
        act_sy    <= nxt_sy;
`endif
      end
    end
  end

  // Effective values: a commit on this edge is visible to this edge's pixel
  always_comb begin
    fill_en = frameStart ? nxt_fill  : act_fill;
    tile_en = frameStart ? nxt_tile  : act_tile;
    solid   = frameStart ? nxt_solid : act_solid;
`ifdef BG_SCROLL_EN
    scroll_x = frameStart ? nxt_sx : act_sx;
    scroll_y = frameStart ? nxt_sy : act_sy;
`endif
  end

endmodule

// File: rtl/bg_fill_engine.sv
// Background filler: replaces transparent pixel indices with either a solid
// colour or a scrolled, wrapped tile-map entry read from an external
// synchronous RAM. Two-stage pipeline, fixed latency of 2 edges, no stall.
// Handshake: enable qualifies x/y/indexIn on each rising edge; validOut
// qualifies indexOut exactly two edges later. There is no backpressure.
// Optional feature macro: BG_SCROLL_EN (scroll registers and adders).
module bg_fill_engine
  import bg_fill_pkg::*;
#(
  parameter int INDEX_W       = BG_INDEX_W,
  parameter int COORD_W       = BG_COORD_W,
  parameter int TILE_LOG2     = BG_TILE_LOG2,
  parameter int MAP_COLS_LOG2 = BG_MAP_COLS_LOG2,
  parameter int MAP_ROWS_LOG2 = BG_MAP_ROWS_LOG2,
  parameter int TRANSPARENT   = BG_TRANSPARENT
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic [COORD_W-1:0]                     x,
  input  logic [COORD_W-1:0]                     y,
  input  logic [INDEX_W-1:0]                     indexIn,
  input  logic                                   frameStart,
  input  logic                                   regWe,
  input  logic [1:0]                             regAddr,
  input  logic [15:0]                            regData,
  output logic [MAP_COLS_LOG2+MAP_ROWS_LOG2-1:0] mapAddr,
  output logic                                   mapRe,
  input  logic [INDEX_W-1:0]                     mapData,
  output logic [INDEX_W-1:0]                     indexOut,
  output logic                                   validOut
);

  localparam int ADDR_W = MAP_COLS_LOG2 + MAP_ROWS_LOG2;

  logic               eff_fill, eff_tile;
  logic [INDEX_W-1:0] eff_solid;
  logic [COORD_W-1:0] tx, ty;
  logic [ADDR_W-1:0]  map_addr_d;
  logic               unused_coord;

  // Stage 1 (after the sampling edge) and stage 2 (after the RAM edge)
  logic               s1_valid, s1_fill, s1_tile;
  logic [INDEX_W-1:0] s1_index, s1_solid;
  logic               s2_valid, s2_fill, s2_tile;
  logic [INDEX_W-1:0] s2_index, s2_solid;
  logic [INDEX_W-1:0] fill_result;

`ifdef BG_SCROLL_EN
  logic [COORD_W-1:0] eff_sx, eff_sy;
`endif

  bg_fill_regs #(
    .INDEX_W (INDEX_W)
`ifdef BG_SCROLL_EN
    ,
    .COORD_W (COORD_W)
`endif
  ) u_regs (
    .clk        (clk),
    .reset      (reset),
    .frameStart (frameStart),
    .regWe      (regWe),
    .regAddr    (regAddr),
    .regData    (regData),
`ifdef BG_SCROLL_EN
    .scroll_x   (eff_sx),
    .scroll_y   (eff_sy),
`endif
    .fill_en    (eff_fill),
    .tile_en    (eff_tile),
    .solid      (eff_solid)
  );

  // Scrolled coordinates wrap naturally at the coordinate width
`ifdef BG_SCROLL_EN
  assign tx = x + eff_sx;
  assign ty = y + eff_sy;
`else
  assign tx = x;
  assign ty = y;
`endif

  // Row-major map address; dropping high tile bits makes the map wrap
  assign map_addr_d   = {ty[TILE_LOG2 +: MAP_ROWS_LOG2], tx[TILE_LOG2 +: MAP_COLS_LOG2]};
  assign unused_coord = ^{tx, ty};

  // Stage 1: sample pixel, issue map read, freeze the settings for this pixel
  always_ff @(posedge clk) begin
    if (reset) begin
      mapAddr  <= '0;
      mapRe    <= 1'b0;
      s1_valid <= 1'b0;
      s1_fill  <= 1'b0;
      s1_tile  <= 1'b0;
      s1_index <= '0;
      s1_solid <= '0;
    end else begin
      s1_valid <= enable;
      mapRe    <= enable & eff_fill & eff_tile;
      if (enable) begin
        mapAddr  <= map_addr_d;
        s1_index <= indexIn;
        s1_fill  <= eff_fill;
        s1_tile  <= eff_tile;
        s1_solid <= eff_solid;
      end
    end
  end

  // Stage 2: carry the pixel while the RAM latches the address
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_fill  <= 1'b0;
      s2_tile  <= 1'b0;
      s2_index <= '0;
      s2_solid <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_index <= s1_index;
        s2_fill  <= s1_fill;
        s2_tile  <= s1_tile;
        s2_solid <= s1_solid;
      end
    end
  end

  // Result select: only transparent pixels with fill enabled are replaced
  always_comb begin
    fill_result = s2_index;
    if (s2_fill && (s2_index == INDEX_W'(TRANSPARENT))) begin
      fill_result = s2_tile ? mapData : s2_solid;
    end
  end

  // Output register: indexOut holds across bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      indexOut <= '0;
      validOut <= 1'b0;
    end else begin
      validOut <= s2_valid;
      if (s2_valid) begin
        indexOut <= fill_result;
      end
    end
  end

endmodule

// File: tb/tb_bg_fill_engine.sv
// Self-checking bench for bg_fill_engine: directed vectors, a frame-level
// behavioural model with an expected-output queue, and a per-cycle compare.
module tb_bg_fill_engine;

  localparam int IW   = 9;
  localparam int CW   = 10;
  localparam int AW   = 11;

  // Clock and reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          enable = 1'b0;
  logic [CW-1:0] x = '0, y = '0;
  logic [IW-1:0] index_in = '0;
  logic          frame_start = 1'b0;
  logic          reg_we = 1'b0;
  logic [1:0]    reg_addr = '0;
  logic [15:0]   reg_data = '0;
  logic [AW-1:0] map_addr;
  logic          map_re;
  logic [IW-1:0] map_data = '0;
  logic [IW-1:0] index_out;
  logic          valid_out;

  bg_fill_engine dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .x          (x),
    .y          (y),
    .indexIn    (index_in),
    .frameStart (frame_start),
    .regWe      (reg_we),
    .regAddr    (reg_addr),
    .regData    (reg_data),
    .mapAddr    (map_addr),
    .mapRe      (map_re),
    .mapData    (map_data),
    .indexOut   (index_out),
    .validOut   (valid_out)
  );

  // Map RAM contents and synchronous read port
  logic [IW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = IW'((i * 37 + 11) % 512);
    mem[66] = 9'h042;
  end
  always @(posedge clk) if (map_re) map_data <= mem[map_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: register semantics plus a fixed 2-edge delay queue
  logic [IW:0]   exp_q[$];
  logic          model_live = 1'b0;
  logic          exp_valid = 1'b0, exp_mapre = 1'b0;
  logic [IW-1:0] exp_index = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [1:0]    pend_mode, act_mode;
  logic [IW-1:0] pend_solid, act_solid;
  logic [CW-1:0] pend_sx, pend_sy, act_sx, act_sy, mtx, mty;
  logic [IW:0]   head, entry;
  logic [IW-1:0] res;

  always @(posedge clk) begin
    if (reset) begin
      pend_mode = '0; act_mode = '0; pend_solid = '0; act_solid = '0;
      pend_sx = '0; pend_sy = '0; act_sx = '0; act_sy = '0;
      exp_q.delete();
      exp_q.push_back('0);
      exp_q.push_back('0);
      exp_valid = 1'b0; exp_index = '0; exp_mapre = 1'b0; exp_addr = '0;
      model_live = 1'b1;
    end else if (model_live) begin
      head = exp_q.pop_front();
      exp_valid = head[IW];
      if (head[IW]) exp_index = head[IW-1:0];
      if (reg_we) begin
        case (reg_addr)
          2'd0: pend_mode = reg_data[1:0];
          2'd1: pend_solid = reg_data[IW-1:0];
`ifdef BG_SCROLL_EN
          2'd2: pend_sx = reg_data[CW-1:0];
          2'd3: pend_sy = reg_data[CW-1:0];
`endif
          default: ;
        endcase
      end
      if (frame_start) begin
        act_mode = pend_mode; act_solid = pend_solid;
        act_sx = pend_sx; act_sy = pend_sy;
      end
      entry = '0;
      exp_mapre = 1'b0;
      if (enable) begin
        mtx = x + act_sx;
        mty = y + act_sy;
        exp_addr = AW'(int'(mty / 8) % 32 * 64 + int'(mtx / 8) % 64);
        exp_mapre = act_mode[0] && act_mode[1];
        if (!act_mode[0] || index_in != 0) res = index_in;
        else if (!act_mode[1]) res = act_solid;
        else res = mem[exp_addr];
        entry = {1'b1, res};
      end
      exp_q.push_back(entry);
    end
  end

  // Per-cycle compare against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        check("validOut", valid_out, exp_valid);
        check("indexOut", index_out, exp_index);
        check("mapRe", map_re, exp_mapre);
        if (exp_mapre) check("mapAddr", map_addr, exp_addr);
      end
    end
  end

  // Driver tasks: inputs change just after the falling edge
  task automatic step(input logic en, input logic [CW-1:0] px, input logic [CW-1:0] py,
                      input logic [IW-1:0] idx, input logic we, input logic [1:0] ra,
                      input logic [15:0] rd, input logic fs);
    enable = en; x = px; y = py; index_in = idx;
    reg_we = we; reg_addr = ra; reg_data = rd; frame_start = fs;
    @(negedge clk);
    enable = 1'b0; reg_we = 1'b0; frame_start = 1'b0;
  endtask

  task automatic pix(input logic [CW-1:0] px, input logic [CW-1:0] py, input logic [IW-1:0] idx);
    step(1'b1, px, py, idx, 1'b0, 2'd0, 16'h0, 1'b0);
  endtask

  task automatic wr(input logic [1:0] ra, input logic [15:0] rd, input logic fs);
    step(1'b0, '0, '0, '0, 1'b1, ra, rd, fs);
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, 2'd0, 16'h0, 1'b0);
  endtask

  task automatic fs_only();
    step(1'b0, '0, '0, '0, 1'b0, 2'd0, 16'h0, 1'b1);
  endtask

  // Send one pixel and check its result two edges later
  task automatic pix_expect(input string name, input logic [CW-1:0] px, input logic [CW-1:0] py,
                            input logic [IW-1:0] idx, input logic [IW-1:0] want);
    pix(px, py, idx);
    idle();
    idle();
    check({name, "_valid"}, valid_out, 1'b1);
    check({name, "_index"}, index_out, want);
  endtask

  // Directed sequence
  initial begin
    repeat (2) @(negedge clk);
    check("rst_index", index_out, 9'h0);
    check("rst_valid", valid_out, 1'b0);
    check("rst_mapre", map_re, 1'b0);
    check("rst_mapaddr", map_addr, 11'h0);
    reset = 1'b0;
    idle();

    // Passthrough after reset, then a bubble holds indexOut
    pix(3, 4, 5);
    check("pass_mapre", map_re, 1'b0);
    idle(); idle();
    check("pass_valid", valid_out, 1'b1);
    check("pass_index", index_out, 9'd5);
    idle();
    check("bubble_valid", valid_out, 1'b0);
    check("bubble_hold", index_out, 9'd5);

    // Pending writes only take effect after frameStart
    wr(2'd1, 16'h01A3, 1'b0);
    wr(2'd0, 16'h0001, 1'b0);
    pix_expect("pending", 0, 0, 0, 9'h000);
    fs_only();
    pix_expect("solid", 0, 0, 0, 9'h1A3);
    pix_expect("opaque", 0, 0, 7, 9'h007);

    // Tile mode, no scroll
    wr(2'd0, 16'h0003, 1'b1);
    pix(17, 9, 0);
    check("tile_mapre", map_re, 1'b1);
    check("tile_mapaddr", map_addr, 11'd66);
    idle(); idle();
    check("tile_index", index_out, 9'h042);
    pix_expect("tile_opaque", 17, 9, 9, 9'h009);

    // Scroll wrap (writes are ignored when scrolling is not built in)
    wr(2'd2, 16'd1020, 1'b1);
    pix(10, 9, 0);
`ifdef BG_SCROLL_EN
    check("scrollx_mapaddr", map_addr, 11'd64);
    idle(); idle();
    check("scrollx_index", index_out, 9'h14B);
`else
    check("scrollx_mapaddr", map_addr, 11'd65);
    idle(); idle();
    check("scrollx_index", index_out, 9'h170);
`endif
    wr(2'd2, 16'd0, 1'b1);
    wr(2'd3, 16'd1023, 1'b1);
    pix(0, 8, 0);
`ifdef BG_SCROLL_EN
    check("scrolly_mapaddr", map_addr, 11'd0);
`else
    check("scrolly_mapaddr", map_addr, 11'd64);
`endif
    wr(2'd3, 16'd0, 1'b1);
    pix(511, 0, 0);
    check("col63", map_addr, 11'd63);
    pix(512, 0, 0);
    check("colwrap", map_addr, 11'd0);
    pix(0, 255, 0);
    check("row31", map_addr, 11'd1984);
    pix(0, 256, 0);
    check("rowwrap", map_addr, 11'd0);
    idle(); idle();

    // Write coinciding with frameStart, and commit on the pixel's own edge
    wr(2'd0, 16'h0001, 1'b1);
    wr(2'd1, 16'h0007, 1'b1);
    pix_expect("we_fs", 0, 0, 0, 9'h007);
    wr(2'd1, 16'h0055, 1'b0);
    step(1'b1, 0, 0, 0, 1'b0, 2'd0, 16'h0, 1'b1);
    idle(); idle();
    check("same_edge_commit", index_out, 9'h055);
    wr(2'd1, 16'hFFFF, 1'b1);
    pix_expect("solid_trunc", 0, 0, 0, 9'h1FF);

    // Back-to-back tile stream checked by the model
    wr(2'd0, 16'h0003, 1'b1);
    for (int i = 0; i < 40; i++) begin
      pix(CW'((i * 29) % 1024), CW'((i * 13) % 1024), (i % 3 == 0) ? IW'(i) : IW'(0));
    end
    idle(); idle();

    // Stream with a bubble and a mid-stream reset
    pix(0, 0, 1);
    pix(0, 0, 2);
    idle();
    check("stream1_valid", valid_out, 1'b1);
    check("stream1_index", index_out, 9'd1);
    pix(0, 0, 4);
    check("stream2_valid", valid_out, 1'b1);
    check("stream2_index", index_out, 9'd2);
    reset = 1'b1;
    pix(0, 0, 5);
    reset = 1'b0;
    check("stream_rst_valid", valid_out, 1'b0);
    check("stream_rst_index", index_out, 9'd0);
    pix(0, 0, 6);
    check("flush1_valid", valid_out, 1'b0);
    idle();
    check("flush2_valid", valid_out, 1'b0);
    idle();
    check("after_rst_valid", valid_out, 1'b1);
    check("after_rst_index", index_out, 9'd6);
    pix(0, 0, 0);
    check("after_rst_mapre", map_re, 1'b0);
    idle(); idle();
    check("after_rst_pass", index_out, 9'd0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
